// File: rtl/sram_arb_pkg.sv
// Shared types and address-map constants for the testbench memory-port arbiter.
// Region bases default to the ariane_soc memory map.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_ROM  = 2'd1,
        REG_DRAM = 2'd2,
        REG_GPIO = 2'd3
    } region_e;

    localparam logic [63:0] ROM_BASE    = 64'h0000_0000_0001_0000;
    localparam logic [63:0] ROM_LENGTH  = 64'h0000_0000_0001_0000;
    localparam logic [63:0] DRAM_BASE   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DRAM_LENGTH = 64'h0000_0000_4000_0000;
    localparam logic [63:0] GPIO_BASE   = 64'h0000_0000_4000_0000;
    localparam logic [63:0] GPIO_LENGTH = 64'h0000_0000_0000_1000;

    // Operands are zero-extended 64-bit values, so base+len cannot wrap in 65 bits.
    function automatic logic in_range(input logic [64:0] addr,
                                      input logic [64:0] base,
                                      input logic [64:0] len);
        logic [64:0] lim;
        lim = base + len;
        return (addr >= base) && (addr < lim);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// wrapping modulo NumReq, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter  int unsigned NumReq = 2,
    localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              valid
);

    // Scan from ptr and keep the first hit.
    always_comb begin
        int unsigned cand_s;
        logic [IdxW-1:0] cand_idx_s;
        gnt        = '0;
        idx        = '0;
        valid      = 1'b0;
        cand_s     = 32'd0;
        cand_idx_s = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand_s = 32'(ptr) + off;
            if (cand_s >= NumReq) begin
                cand_s = cand_s - NumReq;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IdxW'(cand_s);
            if (!valid && req[cand_idx_s]) begin
                valid           = 1'b1;
                gnt[cand_idx_s] = 1'b1;
                idx             = cand_idx_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the bare-testbench memory port between NumReq requesters: round-robin
// grant with bounded locking, region decode, and a one-cycle response stage.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter  int unsigned NumReq        = 2,
    parameter  int unsigned AddrWidth     = 64,
    parameter  int unsigned DataWidth     = 64,
    parameter  int unsigned MaxLockCycles = 8,
    parameter  logic [63:0] RomBase       = ROM_BASE,
    parameter  logic [63:0] RomLength     = ROM_LENGTH,
    parameter  logic [63:0] DramBase      = DRAM_BASE,
    parameter  logic [63:0] DramLength    = DRAM_LENGTH,
    parameter  logic [63:0] GpioBase      = GPIO_BASE,
    parameter  logic [63:0] GpioLength    = GPIO_LENGTH,
    localparam int unsigned BeWidth       = DataWidth / 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0]                    req_i,
    input  logic [NumReq-1:0]                    we_i,
    input  logic [NumReq-1:0]                    lock_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0][BeWidth-1:0]       be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
    output logic [NumReq-1:0]                    gnt_o,
    output logic [NumReq-1:0]                    rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 rom_req_o,
    output logic                                 dram_req_o,
    output logic                                 gpio_req_o,
    output logic                                 mem_we_o,
    output logic [AddrWidth-1:0]                 mem_addr_o,
    output logic [BeWidth-1:0]                   mem_be_o,
    output logic [DataWidth-1:0]                 mem_wdata_o,
    input  logic [DataWidth-1:0]                 rom_rdata_i,
    input  logic [DataWidth-1:0]                 dram_rdata_i,
    input  logic [DataWidth-1:0]                 gpio_rdata_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxLockCycles + 1);

    logic [NumReq-1:0]    gnt_s;
    logic [IdxW-1:0]      win_idx_s;
    logic                 any_gnt_s;
    logic [IdxW-1:0]      ptr_r;
    logic [CntW-1:0]      lock_cnt_r;
    logic [AddrWidth-1:0] addr_s;
    logic [64:0]          addr_ext_s;
    region_e              region_s;
    logic                 resp_valid_r;
    logic [IdxW-1:0]      resp_owner_r;
    region_e              resp_region_r;
    logic                 resp_we_r;

    rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (ptr_r),
        .gnt   (gnt_s),
        .idx   (win_idx_s),
        .valid (any_gnt_s)
    );

    assign gnt_o = gnt_s;

    // Region decode of the granted address; ROM, DRAM, GPIO in priority order.
    always_comb begin
        addr_s      = addr_i[win_idx_s];
        addr_ext_s  = 65'(addr_s);
        region_s    = REG_NONE;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (!any_gnt_s) begin
            region_s = REG_NONE;
        end else if (in_range(addr_ext_s, 65'(RomBase), 65'(RomLength))) begin
            region_s   = REG_ROM;
            mem_addr_o = addr_s - AddrWidth'(RomBase);
        end else if (in_range(addr_ext_s, 65'(DramBase), 65'(DramLength))) begin
            region_s   = REG_DRAM;
            mem_addr_o = addr_s - AddrWidth'(DramBase);
        end else if (in_range(addr_ext_s, 65'(GpioBase), 65'(GpioLength))) begin
            region_s   = REG_GPIO;
            mem_addr_o = addr_s - AddrWidth'(GpioBase);
        end else begin
            region_s = REG_NONE;
        end
        if (any_gnt_s) begin
            mem_we_o    = we_i[win_idx_s];
            mem_be_o    = be_i[win_idx_s];
            mem_wdata_o = wdata_i[win_idx_s];
        end else begin
            mem_we_o = 1'b0;
        end
    end

    assign rom_req_o  = (region_s == REG_ROM);
    assign dram_req_o = (region_s == REG_DRAM);
    assign gpio_req_o = (region_s == REG_GPIO);

    // Pointer and lock counter: a locked owner keeps the pointer until its run is exhausted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r      <= '0;
            lock_cnt_r <= '0;
        end else if (any_gnt_s) begin
            if (lock_i[win_idx_s] && (lock_cnt_r < CntW'(MaxLockCycles - 1))) begin
                ptr_r      <= win_idx_s;
                lock_cnt_r <= lock_cnt_r + CntW'(1);
            end else begin
                ptr_r      <= (win_idx_s == IdxW'(NumReq - 1)) ? '0 : win_idx_s + IdxW'(1);
                lock_cnt_r <= '0;
            end
        end else begin
            lock_cnt_r <= '0;
        end
    end

    // Response stage: remember who was served and from where.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_r  <= 1'b0;
            resp_owner_r  <= '0;
            resp_region_r <= REG_NONE;
            resp_we_r     <= 1'b0;
        end else begin
            resp_valid_r  <= any_gnt_s;
            resp_owner_r  <= win_idx_s;
            resp_region_r <= region_s;
            resp_we_r     <= mem_we_o;
        end
    end

    // Response outputs, with read data steered by the registered region.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (resp_valid_r) begin
            rvalid_o[resp_owner_r] = 1'b1;
        end else begin
            rvalid_o = '0;
        end
        if (resp_valid_r && !resp_we_r) begin
            case (resp_region_r)
                REG_ROM:  rdata_o = rom_rdata_i;
                REG_DRAM: rdata_o = dram_rdata_i;
                REG_GPIO: rdata_o = gpio_rdata_i;
                default:  rdata_o = '0;
            endcase
        end else begin
            rdata_o = '0;
        end
    end

    assign err_o = resp_valid_r && (resp_region_r == REG_NONE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed steps from the test plan
// followed by randomized traffic checked against a behavioural reference.
module tb_sram_port_arbiter;

    localparam int N  = 2;
    localparam int ML = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, we, lock;
    logic [1:0][63:0]  addr;
    logic [1:0][7:0]   be;
    logic [1:0][63:0]  wdata;
    logic [1:0]        gnt_o, rvalid_o;
    logic [63:0]       rdata_o, mem_addr_o, mem_wdata_o;
    logic              err_o, rom_req_o, dram_req_o, gpio_req_o, mem_we_o;
    logic [7:0]        mem_be_o;
    logic [63:0]       rom_rd, dram_rd, gpio_rd;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .lock_i       (lock),
        .addr_i       (addr),
        .be_i         (be),
        .wdata_i      (wdata),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .rom_req_o    (rom_req_o),
        .dram_req_o   (dram_req_o),
        .gpio_req_o   (gpio_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .rom_rdata_i  (rom_rd),
        .dram_rdata_i (dram_rd),
        .gpio_rdata_i (gpio_rd)
    );

    // Memory macros: 16 words per region, indexed by offset bits [6:3].
    logic [63:0] rom_mem [16];
    logic [63:0] dram_mem [16];
    logic [63:0] gpio_mem [16];

    function automatic logic [63:0] init_word(input int r, input int i);
        if (r == 2 && i == 2) return 64'h0000_0000_DEAD_BEEF;
        return (64'(r) << 56) | (64'(i) * 64'h0000_0000_0001_0101);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] b);
        logic [63:0] res;
        res = o;
        for (int k = 0; k < 8; k++) if (b[k]) res[k*8 +: 8] = n[k*8 +: 8];
        return res;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rom_mem[i]  <= init_word(1, i);
                dram_mem[i] <= init_word(2, i);
                gpio_mem[i] <= init_word(3, i);
            end
            rom_rd  <= 64'd0;
            dram_rd <= 64'd0;
            gpio_rd <= 64'd0;
        end else begin
            if (rom_req_o) begin
                if (mem_we_o) rom_mem[mem_addr_o[6:3]] <= merge(rom_mem[mem_addr_o[6:3]], mem_wdata_o, mem_be_o);
                else          rom_rd <= rom_mem[mem_addr_o[6:3]];
            end
            if (dram_req_o) begin
                if (mem_we_o) dram_mem[mem_addr_o[6:3]] <= merge(dram_mem[mem_addr_o[6:3]], mem_wdata_o, mem_be_o);
                else          dram_rd <= dram_mem[mem_addr_o[6:3]];
            end
            if (gpio_req_o) begin
                if (mem_we_o) gpio_mem[mem_addr_o[6:3]] <= merge(gpio_mem[mem_addr_o[6:3]], mem_wdata_o, mem_be_o);
                else          gpio_rd <= gpio_mem[mem_addr_o[6:3]];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: round-robin pointer, length of the current kept-pointer streak,
    // and the response expected in the following cycle.
    int          m_ptr, m_streak;
    logic        m_kept;
    logic        m_valid, m_err;
    int          m_owner;
    logic [63:0] m_rdata;
    logic [1:0]  last_gnt;
    logic [63:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address map from the documented defaults: 0 none, 1 ROM, 2 DRAM, 3 GPIO.
    function automatic int ref_region(input logic [63:0] a, output logic [63:0] off);
        off = 64'd0;
        if (a >= 64'h1_0000 && a < 64'h2_0000)            begin off = a - 64'h1_0000;     return 1; end
        if (a >= 64'h8000_0000 && a < 64'hC000_0000)      begin off = a - 64'h8000_0000;  return 2; end
        if (a >= 64'h4000_0000 && a < 64'h4000_1000)      begin off = a - 64'h4000_0000;  return 3; end
        return 0;
    endfunction

    function automatic logic [63:0] ref_read(input int r, input logic [63:0] off);
        logic [3:0] i;
        i = off[6:3];
        case (r)
            1: return rom_mem[i];
            2: return dram_mem[i];
            3: return gpio_mem[i];
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_streak = 0; m_kept = 1'b0;
        m_valid = 1'b0; m_err = 1'b0; m_owner = 0; m_rdata = 64'd0;
    endtask

    // One bus cycle: drive at the falling edge, check outputs, advance the model.
    task automatic cycle(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [7:0] b0, input logic [7:0] b1);
        int win, rg;
        logic [63:0] a, off;
        logic [2:0] exp_strb;
        @(negedge clk);
        req = r; we = w; lock = l;
        addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
        #1;
        chk("rvalid", 64'(rvalid_o), m_valid ? (64'd1 << m_owner) : 64'd0);
        if (m_valid) begin
            chk("err", 64'(err_o), 64'(m_err));
            chk("rdata", rdata_o, m_rdata);
        end
        last_rdata = rdata_o;
        last_err   = err_o;
        last_gnt   = gnt_o;
        win = -1;
        for (int off_i = 0; off_i < N; off_i++)
            if (win < 0 && r[(m_ptr + off_i) % N]) win = (m_ptr + off_i) % N;
        chk("gnt", 64'(gnt_o), (win >= 0) ? (64'd1 << win) : 64'd0);
        if (win >= 0) begin
            a  = win ? a1 : a0;
            rg = ref_region(a, off);
            exp_strb = (rg == 0) ? 3'b000 : (3'b001 << (rg - 1));
            chk("strobes", 64'({gpio_req_o, dram_req_o, rom_req_o}), 64'(exp_strb));
            chk("mem_addr", mem_addr_o, off);
            chk("mem_we", 64'(mem_we_o), 64'(w[win]));
            chk("mem_be", 64'(mem_be_o), 64'(win ? b1 : b0));
            chk("mem_wdata", mem_wdata_o, win ? d1 : d0);
            m_valid = 1'b1;
            m_owner = win;
            m_err   = (rg == 0);
            m_rdata = (w[win] || rg == 0) ? 64'd0 : ref_read(rg, off);
            m_streak = m_kept ? m_streak + 1 : 1;
            m_kept   = l[win] && (m_streak < ML);
            m_ptr    = m_kept ? win : (win + 1) % N;
        end else begin
            chk("strobes_idle", 64'({gpio_req_o, dram_req_o, rom_req_o}), 64'd0);
            m_valid = 1'b0;
            m_kept  = 1'b0;
        end
    endtask

    task automatic idle();
        cycle(2'b00, 2'b00, 2'b00, 64'd0, 64'd0, 64'd0, 64'd0, 8'h00, 8'h00);
    endtask

    logic [63:0] edges [7];

    initial begin
        int first_r0;
        logic p0;
        edges[0] = 64'h0000_0000_0001_FFF8; edges[1] = 64'h0000_0000_0002_0000;
        edges[2] = 64'h0000_0000_0000_FFF8; edges[3] = 64'h0000_0000_4000_0FF8;
        edges[4] = 64'h0000_0000_4000_1000; edges[5] = 64'h0000_0000_BFFF_FFF8;
        edges[6] = 64'h0000_0000_C000_0000;
        rst = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00;
        addr = '0; be = '0; wdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_strobes", 64'({gpio_req_o, dram_req_o, rom_req_o}), 64'd0);
        rst = 1'b0;

        // Single DRAM read of preloaded word 2.
        cycle(2'b01, 2'b00, 2'b00, 64'h8000_0010, 64'd0, 64'd0, 64'd0, 8'hFF, 8'h00);
        chk("single_gnt", 64'(last_gnt), 64'h1);
        idle();
        chk("single_rdata", last_rdata, 64'h0000_0000_DEAD_BEEF);

        // Both requesting, no lock: grants alternate.
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 2'b00, 2'b00, 64'h8000_0000 + 64'(i*8), 64'h1_0000 + 64'(i*8),
                  64'd0, 64'd0, 8'hFF, 8'hFF);
        cycle(2'b01, 2'b00, 2'b00, 64'h8000_0018, 64'd0, 64'd0, 64'd0, 8'hFF, 8'h00);

        // req1 locked for 12 cycles while req0 waits: forced rotation after 8 grants.
        p0 = 1'b1; first_r0 = -1;
        for (int i = 0; i < 12; i++) begin
            cycle({1'b1, p0}, 2'b00, 2'b10, 64'h8000_0020, 64'h8000_0000 + 64'(i*8),
                  64'd0, 64'd0, 8'hFF, 8'hFF);
            if (last_gnt == 2'b01) begin
                p0 = 1'b0;
                if (first_r0 < 0) first_r0 = i;
            end
            if (i == 9) chk("lock_resume", 64'(last_gnt), 64'h2);
        end
        chk("lock_rotate_at", 64'(first_r0), 64'd8);
        idle();

        // Unmapped read.
        cycle(2'b01, 2'b00, 2'b00, 64'h2000_0000, 64'd0, 64'd0, 64'd0, 8'hFF, 8'h00);
        chk("unmapped_strobes", 64'({gpio_req_o, dram_req_o, rom_req_o}), 64'd0);
        idle();
        chk("unmapped_err", 64'(last_err), 64'd1);
        chk("unmapped_rdata", last_rdata, 64'd0);

        // GPIO write of 1 with full byte enables.
        cycle(2'b10, 2'b10, 2'b00, 64'd0, 64'h4000_0000, 64'd0, 64'd1, 8'h00, 8'hFF);
        chk("gpio_strobe", 64'(gpio_req_o), 64'd1);
        chk("gpio_we", 64'(mem_we_o), 64'd1);
        idle();

        // Reset in the cycle after a grant drops the response and re-homes the pointer.
        cycle(2'b01, 2'b00, 2'b00, 64'h8000_0008, 64'd0, 64'd0, 64'd0, 8'hFF, 8'h00);
        #2;
        rst = 1'b1; req = 2'b00;
        model_reset();
        @(negedge clk); #1;
        chk("midrst_rvalid", 64'(rvalid_o), 64'd0);
        rst = 1'b0;
        cycle(2'b11, 2'b00, 2'b00, 64'h8000_0000, 64'h8000_0008, 64'd0, 64'd0, 8'hFF, 8'hFF);
        chk("midrst_first_gnt", 64'(last_gnt), 64'h1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [63:0] ra [2];
            for (int j = 0; j < 2; j++) begin
                case ($urandom_range(0, 4))
                    0: ra[j] = 64'h1_0000     + 64'({$urandom_range(0, 15), 3'b000});
                    1: ra[j] = 64'h8000_0000  + 64'({$urandom_range(0, 15), 3'b000});
                    2: ra[j] = 64'h4000_0000  + 64'({$urandom_range(0, 15), 3'b000});
                    3: ra[j] = 64'h2000_0000  + 64'({$urandom_range(0, 15), 3'b000});
                    default: ra[j] = edges[$urandom_range(0, 6)];
                endcase
            end
            cycle(2'($urandom), 2'($urandom), 2'($urandom), ra[0], ra[1],
                  {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 8'($urandom));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
